// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial sequence detector.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_cmp.sv
// Serial shift register with fill counter and a length-masked pattern comparator.
// hit is combinational and describes the edge about to happen: it compares the
// register contents as they will be once the current D has been shifted in.
module seq_shift_cmp #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             D,
  output logic             hit
);

  logic [PAT_W-1:0] sr;
  logic [PAT_W-1:0] sr_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;

  // Next shift-register/fill values and the masked compare on them.
  always_comb begin
    sr_next   = {sr[PAT_W-2:0], D};
    fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (fill_next >= len) && ((sr_next & mask) == (pattern & mask));
  end

  // Shift register and fill counter; a non-overlapped hit restarts the fill so no bit is reused.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sr   <= '0;
      fill <= '0;
    end else if (clr) begin
      sr   <= '0;
      fill <= '0;
    end else if (shift_en) begin
      sr   <= sr_next;
      fill <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller for a programmable serial sequence detector: config handshake,
// IDLE/RUN/DONE scheduling, match pulse and saturating match counter.
// Config handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready;
// the source keeps cfg_valid and its payload stable until that edge, and cfg_ready
// is high only while the controller is in IDLE or DONE.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             D,
  output logic             match,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_dbg
);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic             cfg_loaded;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             match_n;
  logic             accept;
  logic             go;
  logic             shift_en;
  logic             clr;
  logic             hit;
  logic [LEN_W-1:0] len_c;

  assign cfg_ready = (state == S_IDLE) || (state == S_DONE);
  assign accept    = cfg_valid && cfg_ready;
  // abort wins over start, and a config transfer on the same edge swallows start.
  assign go        = start && cfg_loaded && !accept && !abort;
  assign cnt_inc   = match_cnt + 1'b1;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Out-of-range lengths are clamped to the supported 1..PAT_W window.
  always_comb begin
    len_c = cfg_len;
    if (cfg_len == '0) len_c = LEN_W'(1);
    else if (cfg_len > LEN_W'(PAT_W)) len_c = LEN_W'(PAT_W);
  end

  seq_shift_cmp #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shift_cmp (
    .clk      (clk),
    .res_n    (res_n),
    .shift_en (shift_en),
    .clr      (clr),
    .len      (len_q),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .D        (D),
    .hit      (hit)
  );

  // Next state, shifter control, next match pulse and next count.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    clr      = 1'b0;
    cnt_n    = match_cnt;
    match_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_RUN;
          clr     = 1'b1;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          shift_en = 1'b1;
          if (hit) begin
            match_n = 1'b1;
            cnt_n   = (&match_cnt) ? match_cnt : cnt_inc;
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (go) begin
          state_n = S_RUN;
          clr     = 1'b1;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counter and match pulse registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= S_IDLE;
      match_cnt <= '0;
      match     <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= cnt_n;
      match     <= match_n;
    end
  end

  // Config registers, loaded on an accepted handshake.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pat_q      <= '0;
      len_q      <= LEN_W'(1);
      ovl_q      <= 1'b0;
      tgt_q      <= '0;
      cfg_loaded <= 1'b0;
    end else if (accept) begin
      pat_q      <= cfg_pattern;
      len_q      <= len_c;
      ovl_q      <= cfg_overlap;
      tgt_q      <= cfg_target;
      cfg_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: expected match/count pairs are queued as each
// bit is driven and popped when the registered result appears after the edge.
module tb_seq_det_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = 3;
  localparam int W     = CNT_W + 1;

  logic             clk;
  logic             res_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             D;
  logic             match;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .res_n       (res_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .D           (D),
    .match       (match),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic eb, input logic ed,
                              input logic er, input logic [CNT_W-1:0] ec);
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
    check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(er));
    check({tag, ".match_cnt"}, 32'(match_cnt), 32'(ec));
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic [CNT_W-1:0] tgt);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Drive n bits (first bit is bits[n-1]); ems marks the bits expected to complete a match.
  task automatic run_bits(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] ems, input logic [CNT_W-1:0] cnt0);
    logic [CNT_W-1:0] ec;
    logic [W-1:0]     got;
    ec = cnt0;
    for (int i = n - 1; i >= 0; i--) begin
      D = bits[i];
      if (ems[i]) ec = ec + 1'b1;
      exp_q.push_back({ems[i], ec});
      tick();
      got = exp_q.pop_front();
      check($sformatf("%s.match[b%0d]", tag, n - i), 32'(match), 32'(got[W-1]));
      check($sformatf("%s.cnt[b%0d]", tag, n - i), 32'(match_cnt), 32'(got[CNT_W-1:0]));
    end
  endtask

  // Directed sequence
  initial begin
    res_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; D = 1'b0;
    #2;
    check("reset.match", 32'(match), 32'd0);
    check_status("reset", 1'b0, 1'b0, 1'b1, 8'd0);
    #10 res_n = 1'b1;
    tick();

    // 1: overlapped 1101, no target
    do_cfg(4'b1101, 3'd4, 1'b1, 8'd0);
    pulse_start();
    check_status("t1.start", 1'b1, 1'b0, 1'b0, 8'd0);
    run_bits("t1", 7, 16'b1101101, 16'b0001001, 8'd0);
    check_status("t1.end", 1'b1, 1'b0, 1'b0, 8'd2);
    pulse_abort();
    check_status("t1.abort", 1'b0, 1'b0, 1'b1, 8'd2);

    // 2: non-overlapped, bits 5-7 cannot complete a second match
    do_cfg(4'b1101, 3'd4, 1'b0, 8'd0);
    pulse_start();
    run_bits("t2", 7, 16'b1101101, 16'b0001000, 8'd0);
    pulse_abort();

    // 3: target 2 stops in DONE; further bits ignored
    do_cfg(4'b1101, 3'd4, 1'b1, 8'd2);
    pulse_start();
    run_bits("t3", 7, 16'b1101101, 16'b0001001, 8'd0);
    check_status("t3.done", 1'b0, 1'b1, 1'b1, 8'd2);
    run_bits("t3.extra", 4, 16'b1101, 16'b0000, 8'd2);
    check_status("t3.hold", 1'b0, 1'b1, 1'b1, 8'd2);

    // 4: restart from DONE, offer config during RUN, then abort+start together
    pulse_start();
    check_status("t4.restart", 1'b1, 1'b0, 1'b0, 8'd0);
    cfg_valid = 1'b1; cfg_pattern = 4'b0000; cfg_len = 3'd4; cfg_overlap = 1'b1; cfg_target = 8'd0;
    run_bits("t4.oldpat", 4, 16'b1101, 16'b0001, 8'd0);
    check("t4.cfg_ready_run", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("t4.abort_match", 32'(match), 32'd0);
    check_status("t4.abort", 1'b0, 1'b0, 1'b1, 8'd1);

    // 5a: len 0 stored as 1, pattern bit 1 -> every 1 matches
    do_cfg(4'b0001, 3'd0, 1'b1, 8'd0);
    pulse_start();
    run_bits("t5.len0", 4, 16'b1011, 16'b1011, 8'd0);
    pulse_abort();
    // 5b: len 7 clamps to 4
    do_cfg(4'b1101, 3'd7, 1'b1, 8'd0);
    pulse_start();
    run_bits("t5.len7", 7, 16'b1101101, 16'b0001001, 8'd0);
    pulse_abort();

    // Config and start on one edge: config stored, start ignored
    cfg_valid = 1'b1; cfg_pattern = 4'b1101; cfg_len = 3'd4; cfg_overlap = 1'b1; cfg_target = 8'd0;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    check_status("cfg_start", 1'b0, 1'b0, 1'b1, 8'd2);

    // 6: asynchronous reset mid-run, then start without config
    pulse_start();
    run_bits("t6", 4, 16'b1101, 16'b0001, 8'd0);
    #2 res_n = 1'b0;
    #1;
    check("t6.rst_match", 32'(match), 32'd0);
    check_status("t6.rst", 1'b0, 1'b0, 1'b1, 8'd0);
    #3 res_n = 1'b1;
    tick();
    pulse_start();
    check_status("t6.nocfg", 1'b0, 1'b0, 1'b1, 8'd0);
    check("t6.nocfg_state", 32'(state_dbg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
